// File: rtl/iir_mc_pkg.sv
// iir_mc_pkg
//   Shared types and width helpers for the multi-channel power-of-two IIR
//   filter. Everything that has to agree between the top level and the
//   state RAM lives here.
//
//   state_e        : controller states (INIT clears RAM, IDLE waits for a
//                    sample set, RUN computes one stage per cycle)
//   clog2_min1()   : address/counter width that never collapses to zero
//   state_width()  : state word width, sample bits plus fraction bits
//   addr_width()   : state RAM address width for a given channel/stage count
package iir_mc_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // A one-entry structure still needs a one-bit index, so the width is
  // never allowed to fall to zero.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Each state word carries K_SHIFT_MAX fraction bits below the sample so
  // that small steps are not lost to truncation at high shift values.
  function automatic int state_width(input int data_bits, input int k_shift_max);
    return data_bits + k_shift_max;
  endfunction

  // One state word per (channel, stage) pair.
  function automatic int addr_width(input int channels, input int max_stages);
    return clog2_min1(channels * max_stages);
  endfunction

endpackage

// File: rtl/iir_state_ram.sv
// iir_state_ram
//   Distributed-style state memory for the filter cascade. Reads are
//   combinational so the single-cycle RUN datapath can read, update and
//   write back the same word within one clock. Contents are not reset; the
//   controller's INIT sweep zeroes every word instead.
//
//   clk    : write clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : asynchronous read address
//   rdata  : asynchronous read data
module iir_state_ram
  import iir_mc_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int WIDTH = 40
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [clog2_min1(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]             wdata,
  input  logic [clog2_min1(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]             rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/iir_filter_pow2_k_mc.sv
// iir_filter_pow2_k_mc
//   Time-multiplexed cascaded first-order IIR low-pass for CHANNELS
//   unsigned sample streams. Each stage computes s' = s + ((x - s) >>> k),
//   i.e. a low-pass with coefficient 1/2^k. One (channel, stage) pair is
//   processed per clock; all channel results are published together with a
//   single OUT_VALID strobe once the last channel finishes.
//
//   clk        : system clock
//   rst_n      : asynchronous active-low reset; forces INIT
//   stages_m1  : cascade depth minus one, latched per sample set
//   k_shift    : filter shift, latched per sample set, clamped to K_SHIFT_MAX
//   clear      : one-cycle pulse; zero all filter state (aborts a pass)
//   in_valid   : in_value carries a new sample set this cycle
//   in_value   : packed samples, channel c at [c*DATA_BITS +: DATA_BITS]
//   busy       : init sweep or pass in progress; samples are not accepted
//   overrun    : in_valid seen while busy, sample set dropped this cycle
//   out_valid  : one-cycle strobe, out_value updated this cycle
//   out_value  : packed filtered outputs, same packing as in_value
module iir_filter_pow2_k_mc
  import iir_mc_pkg::*;
#(
  parameter int DATA_BITS   = 32,
  parameter int CHANNELS    = 4,
  parameter int MAX_STAGES  = 8,
  parameter int K_SHIFT_MAX = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [clog2_min1(MAX_STAGES)-1:0]   stages_m1,
  input  logic [$clog2(K_SHIFT_MAX+1)-1:0]    k_shift,
  input  logic                                clear,
  input  logic                                in_valid,
  input  logic [CHANNELS*DATA_BITS-1:0]       in_value,
  output logic                                busy,
  output logic                                overrun,
  output logic                                out_valid,
  output logic [CHANNELS*DATA_BITS-1:0]       out_value
);

  localparam int IW    = state_width(DATA_BITS, K_SHIFT_MAX);
  localparam int DEPTH = CHANNELS * MAX_STAGES;
  localparam int AW    = addr_width(CHANNELS, MAX_STAGES);
  localparam int CW    = clog2_min1(CHANNELS);
  localparam int SW    = clog2_min1(MAX_STAGES);
  localparam int KW    = $clog2(K_SHIFT_MAX + 1);
  localparam int OW    = CHANNELS * DATA_BITS;

  state_e          state_q,     state_d;
  logic [AW-1:0]   init_cnt_q,  init_cnt_d;
  logic [CW-1:0]   ch_q,        ch_d;
  logic [SW-1:0]   st_q,        st_d;
  logic [SW-1:0]   stages_q,    stages_d;
  logic [KW-1:0]   kshift_q,    kshift_d;
  logic [OW-1:0]   sample_q,    sample_d;
  logic [IW-1:0]   prev_q,      prev_d;
  logic [OW-1:0]   hold_q,      hold_d;
  logic [OW-1:0]   out_value_q, out_value_d;
  logic            out_valid_q, out_valid_d;

  logic [AW-1:0]   run_addr;
  logic            ram_we;
  logic [AW-1:0]   ram_waddr;
  logic [IW-1:0]   ram_wdata;
  logic [IW-1:0]   s_rd;
  logic [IW-1:0]   x_in;
  logic signed [IW:0] d_ext;
  logic signed [IW:0] d_shift;
  logic [IW-1:0]   s_new;

  iir_state_ram #(
    .DEPTH (DEPTH),
    .WIDTH (IW)
  ) u_state_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (run_addr),
    .rdata (s_rd)
  );

  // Single-cycle stage update. Stage 0 takes the latched sample scaled up
  // by the fraction bits; later stages chain from the previous stage result
  // held in prev_q. The difference is formed one bit wider and signed so a
  // falling input shifts arithmetically toward zero instead of wrapping.
  // Because the step always moves s toward x, the sum stays inside IW bits.
  always_comb begin
    run_addr = AW'(int'(ch_q) * MAX_STAGES + int'(st_q));
    if (st_q == '0) begin
      x_in = {sample_q[int'(ch_q)*DATA_BITS +: DATA_BITS], {K_SHIFT_MAX{1'b0}}};
    end else begin
      x_in = prev_q;
    end
    d_ext   = signed'({1'b0, x_in}) - signed'({1'b0, s_rd});
    d_shift = d_ext >>> kshift_q;
    s_new   = IW'(signed'({1'b0, s_rd}) + d_shift);
  end

  // Controller. CLEAR wins over everything and restarts the INIT sweep
  // without writing the word under computation. The output holding
  // register collects each channel's final-stage result during the pass;
  // the visible output is only refreshed from it when the last channel
  // completes, so an aborted pass never changes out_value.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    ch_d        = ch_q;
    st_d        = st_q;
    stages_d    = stages_q;
    kshift_d    = kshift_q;
    sample_d    = sample_q;
    prev_d      = prev_q;
    hold_d      = hold_q;
    out_value_d = out_value_q;
    out_valid_d = 1'b0;
    ram_we      = 1'b0;
    ram_waddr   = run_addr;
    ram_wdata   = s_new;

    if (clear) begin
      state_d    = ST_INIT;
      init_cnt_d = '0;
      ch_d       = '0;
      st_d       = '0;
    end else begin
      unique case (state_q)
        ST_INIT: begin
          ram_we    = 1'b1;
          ram_waddr = init_cnt_q;
          ram_wdata = '0;
          if (init_cnt_q == AW'(DEPTH - 1)) begin
            init_cnt_d = '0;
            state_d    = ST_IDLE;
          end else begin
            init_cnt_d = init_cnt_q + AW'(1);
          end
        end

        ST_IDLE: begin
          if (in_valid) begin
            sample_d = in_value;
            stages_d = (int'(stages_m1) > MAX_STAGES - 1) ? SW'(MAX_STAGES - 1) : stages_m1;
            kshift_d = (int'(k_shift) > K_SHIFT_MAX) ? KW'(K_SHIFT_MAX) : k_shift;
            ch_d     = '0;
            st_d     = '0;
            state_d  = ST_RUN;
          end
        end

        ST_RUN: begin
          ram_we = 1'b1;
          prev_d = s_new;
          if (st_q == stages_q) begin
            hold_d[int'(ch_q)*DATA_BITS +: DATA_BITS] = s_new[IW-1:K_SHIFT_MAX];
            st_d = '0;
            if (ch_q == CW'(CHANNELS - 1)) begin
              ch_d        = '0;
              state_d     = ST_IDLE;
              out_value_d = hold_d;
              out_valid_d = 1'b1;
            end else begin
              ch_d = ch_q + CW'(1);
            end
          end else begin
            st_d = st_q + SW'(1);
          end
        end

        default: begin
          state_d    = ST_INIT;
          init_cnt_d = '0;
        end
      endcase
    end
  end

  // All control and output state clears asynchronously; reset lands in
  // INIT so the RAM is swept to zero as soon as reset releases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      ch_q        <= '0;
      st_q        <= '0;
      stages_q    <= '0;
      kshift_q    <= '0;
      sample_q    <= '0;
      prev_q      <= '0;
      hold_q      <= '0;
      out_value_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      ch_q        <= ch_d;
      st_q        <= st_d;
      stages_q    <= stages_d;
      kshift_q    <= kshift_d;
      sample_q    <= sample_d;
      prev_q      <= prev_d;
      hold_q      <= hold_d;
      out_value_q <= out_value_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Overrun flags the dropped sample in the same cycle it is offered. It is
  // gated by rst_n so it stays low while the block is held in reset.
  assign busy      = (state_q != ST_IDLE);
  assign overrun   = rst_n & in_valid & (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_value = out_value_q;

endmodule

// File: tb/tb_iir_filter_pow2_k_mc.sv
// tb_iir_filter_pow2_k_mc
//   Directed bench for the multi-channel IIR filter at default parameters.
//   A table of hand-computed sample sets covers step response, cascade
//   pass-through and shift clamping; hand-written sequences cover CLEAR and
//   reset aborts, back-to-back overrun and the long downward settle, where
//   a small behavioural model supplies expected outputs.
module tb_iir_filter_pow2_k_mc;

  localparam int DB = 32;
  localparam int CH = 4;
  localparam int MS = 8;
  localparam int KM = 8;
  localparam int OW = CH * DB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    stages_m1 = '0;
  logic [3:0]    k_shift = '0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic [OW-1:0] in_value = '0;
  logic          busy;
  logic          overrun;
  logic          out_valid;
  logic [OW-1:0] out_value;

  int errors = 0;
  int checks = 0;

  longint ms [CH][MS];

  typedef struct {
    int            stages;
    int            kshift;
    logic [OW-1:0] invec;
    logic [OW-1:0] expvec;
    int            lat;
  } vec_t;

  iir_filter_pow2_k_mc #(
    .DATA_BITS   (DB),
    .CHANNELS    (CH),
    .MAX_STAGES  (MS),
    .K_SHIFT_MAX (KM)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stages_m1 (stages_m1),
    .k_shift   (k_shift),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_value  (in_value),
    .busy      (busy),
    .overrun   (overrun),
    .out_valid (out_valid),
    .out_value (out_value)
  );

  always #5 clk = ~clk;

  // Guard against a hung DUT handshake.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count busy cycles from now until idle, noting any cycle where the
  // outputs move away from the expected held value.
  task automatic measureBusy(input logic [OW-1:0] expv, output int n, output int bad);
    n = 0;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      n++;
      if (out_valid !== 1'b0 || out_value !== expv) bad++;
      tick();
    end
    tick();
  endtask

  // Offer one sample set once idle and return the number of cycles from
  // the accept cycle to the OUT_VALID cycle.
  task automatic applyStimulus(input int st, input int k, input logic [OW-1:0] v, output int lat);
    int g;
    g = 0;
    while (busy === 1'b1 && g < 200) begin
      tick();
      g++;
    end
    stages_m1 = 3'(st);
    k_shift   = 4'(k);
    in_value  = v;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (lat < 100) begin
      @(negedge clk);
      if (out_valid === 1'b1) break;
      tick();
      lat++;
    end
    tick();
  endtask

  task automatic modelReset();
    for (int c = 0; c < CH; c++)
      for (int s = 0; s < MS; s++)
        ms[c][s] = 0;
  endtask

  // Behavioural cascade: s' = s + ((x - s) >>> k), k clamped, state keeps
  // KM fraction bits, output is the integer part of the last stage.
  task automatic modelStep(input int st, input int k, input logic [OW-1:0] v, output logic [OW-1:0] o);
    int ke;
    longint x, s, d, sn;
    ke = (k > KM) ? KM : k;
    o = '0;
    for (int c = 0; c < CH; c++) begin
      x = longint'({24'd0, v[c*DB +: DB], 8'd0});
      for (int si = 0; si <= st; si++) begin
        s  = ms[c][si];
        d  = x - s;
        sn = s + (d >>> ke);
        ms[c][si] = sn;
        x = sn;
      end
      o[c*DB +: DB] = x[39:8];
    end
  endtask

  function automatic logic [OW-1:0] allCh(input logic [DB-1:0] v);
    return {v, v, v, v};
  endfunction

  initial begin
    vec_t          tbl [6];
    int            lat, n, bad;
    logic [OW-1:0] mo, pend, v, hi;
    logic [DB-1:0] vv;

    vv = 32'h12345678;
    tbl[0] = '{0, 1,  {32'hFFFFFFFF, 32'd0, 32'd2000, 32'd1000}, {32'h7FFFFFFF, 32'd0, 32'd1000, 32'd500}, 5};
    tbl[1] = '{0, 1,  {32'hFFFFFFFF, 32'd0, 32'd2000, 32'd1000}, {32'hBFFFFFFF, 32'd0, 32'd1500, 32'd750}, 5};
    tbl[2] = '{0, 1,  {32'hFFFFFFFF, 32'd0, 32'd2000, 32'd1000}, {32'hDFFFFFFF, 32'd0, 32'd1750, 32'd875}, 5};
    tbl[3] = '{0, 1,  {32'hFFFFFFFF, 32'd0, 32'd2000, 32'd1000}, {32'hEFFFFFFF, 32'd0, 32'd1875, 32'd937}, 5};
    tbl[4] = '{7, 0,  allCh(vv), allCh(vv), 33};
    tbl[5] = '{0, 12, {vv, 32'd0, 32'h12335678, 32'h12345778},
                      {vv, 32'h12222221, 32'h12345578, 32'h12345679}, 5};

    // Reset release and INIT sweep.
    repeat (3) tick();
    rst_n = 1'b1;
    measureBusy('0, n, bad);
    checkOutput("init_busy_cycles", 128'(n), 128'(32));
    checkOutput("init_outputs_quiet", 128'(bad), 128'(0));
    checkOutput("init_out_value", out_value, '0);

    // Table: step response, cascade pass-through, clamped shift.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(tbl[i].stages, tbl[i].kshift, tbl[i].invec, lat);
      checkOutput($sformatf("row%0d_latency", i), 128'(lat), 128'(tbl[i].lat));
      for (int c = 0; c < CH; c++)
        checkOutput($sformatf("row%0d_ch%0d", i, c), 128'(out_value[c*DB +: DB]),
                    128'(tbl[i].expvec[c*DB +: DB]));
      checkOutput($sformatf("row%0d_valid_pulse", i), 128'(out_valid), 128'(0));
    end

    // CLEAR during RUN cycle 3: no strobe, output held, state zeroed.
    stages_m1 = 3'd0;
    k_shift   = 4'd1;
    in_value  = allCh(32'd1000);
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    measureBusy(tbl[5].expvec, n, bad);
    checkOutput("clear_busy_cycles", 128'(n), 128'(32));
    checkOutput("clear_no_strobe_value_held", 128'(bad), 128'(0));
    checkOutput("clear_value_held", out_value, tbl[5].expvec);
    applyStimulus(0, 1, allCh(32'd256), lat);
    checkOutput("clear_next_latency", 128'(lat), 128'(5));
    checkOutput("clear_next_value", out_value, allCh(32'd128));
    modelReset();
    modelStep(0, 1, allCh(32'd256), mo);

    // Back-to-back IN_VALID: accepts every N+1 = 5 cycles, drops flagged.
    while (busy === 1'b1) tick();
    pend = '0;
    for (int c = 0; c < 16; c++) begin
      for (int ch = 0; ch < CH; ch++)
        v[ch*DB +: DB] = 32'(5000 * (c + 1) + 3 * ch);
      in_value  = v;
      in_valid  = (c < 15);
      stages_m1 = 3'd0;
      k_shift   = 4'd1;
      @(negedge clk);
      checkOutput($sformatf("ovr_overrun_c%0d", c), 128'(overrun), 128'(c < 15 && c % 5 != 0));
      checkOutput($sformatf("ovr_busy_c%0d", c), 128'(busy), 128'(c % 5 != 0));
      checkOutput($sformatf("ovr_valid_c%0d", c), 128'(out_valid), 128'(c > 0 && c % 5 == 0));
      if (c > 0 && c % 5 == 0)
        checkOutput($sformatf("ovr_value_c%0d", c), out_value, pend);
      if (c < 15 && c % 5 == 0)
        modelStep(0, 1, v, pend);
      tick();
    end
    in_valid = 1'b0;

    // Settle high, then drop to zero: model tracks every step, no wrap.
    hi = {32'd1, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    for (int i = 0; i < 48; i++) begin
      applyStimulus(0, 1, hi, lat);
      modelStep(0, 1, hi, mo);
      checkOutput($sformatf("settle_%0d", i), out_value, mo);
    end
    for (int i = 0; i < 80; i++) begin
      applyStimulus(0, 1, '0, lat);
      modelStep(0, 1, '0, mo);
      checkOutput($sformatf("down_%0d", i), out_value, mo);
      if (mo == '0) break;
    end
    checkOutput("down_reached_zero", out_value, '0);

    // Reset asserted at RUN cycle 3: immediate clear, then a fresh INIT.
    stages_m1 = 3'd0;
    k_shift   = 4'd1;
    in_value  = allCh(32'd1000);
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    #1;
    checkOutput("rst_out_value", out_value, '0);
    checkOutput("rst_out_valid", 128'(out_valid), 128'(0));
    checkOutput("rst_busy", 128'(busy), 128'(1));
    checkOutput("rst_overrun", 128'(overrun), 128'(0));
    tick();
    tick();
    in_valid = 1'b0;
    rst_n    = 1'b1;
    measureBusy('0, n, bad);
    checkOutput("rst_busy_cycles", 128'(n), 128'(32));
    checkOutput("rst_outputs_quiet", 128'(bad), 128'(0));
    applyStimulus(0, 1, allCh(32'd256), lat);
    checkOutput("rst_next_latency", 128'(lat), 128'(5));
    checkOutput("rst_next_value", out_value, allCh(32'd128));

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
